// File: rtl/power_gating_top.sv
// Power-gating sequencer for one switchable domain: orders switch, isolation and retention strobes.
// Optional SAVE_TIMEOUT_EN: leave SAVE after SAVE_TIMEOUT cycles even without a block ack.
module power_gating_top #(
    parameter int RAMP_CYCLES    = 4,
    parameter int RESTORE_CYCLES = 2,
    parameter int SAVE_TIMEOUT   = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic power_on_req,
    input  logic power_off_req,
    input  logic ack_from_block_tb,
    output logic isolate_en,
    output logic save_state,
    output logic restore_state,
    output logic power_switch_en,
    output logic power_on_ack,
    output logic power_off_ack
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_PWR_UP  = 3'd1,
        ST_RESTORE = 3'd2,
        ST_ON_ACK  = 3'd3,
        ST_ON      = 3'd4,
        ST_ISOLATE = 3'd5,
        ST_SAVE    = 3'd6,
        ST_PWR_DN  = 3'd7
    } state_t;

    localparam logic [7:0] RAMP_LD    = 8'(RAMP_CYCLES - 1);
    localparam logic [7:0] RESTORE_LD = 8'(RESTORE_CYCLES - 1);
    localparam logic [7:0] SAVE_LD    = 8'(SAVE_TIMEOUT - 1);

    // Output vector order: {iso, sw, save, rest, on_ack, off_ack}
    function automatic logic [5:0] state_outputs(input state_t s);
        logic [5:0] v;
        case (s)
            ST_OFF:     v = 6'b100000;
            ST_PWR_UP:  v = 6'b110000;
            ST_RESTORE: v = 6'b110100;
            ST_ON_ACK:  v = 6'b010010;
            ST_ON:      v = 6'b010000;
            ST_ISOLATE: v = 6'b110000;
            ST_SAVE:    v = 6'b111000;
            ST_PWR_DN:  v = 6'b100001;
            default:    v = 6'b100000;
        endcase
        return v;
    endfunction

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [5:0]  out_r;

    // Sequencer: state, shared down-counter and outputs registered together from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_OFF;
            cnt_r   <= 8'd0;
            out_r   <= state_outputs(ST_OFF);
        end else begin
            case (state_r)
                ST_OFF: begin
                    if (power_on_req) begin
                        state_r <= ST_PWR_UP;
                        cnt_r   <= RAMP_LD;
                        out_r   <= state_outputs(ST_PWR_UP);
                    end
                end
                ST_PWR_UP: begin
                    if (cnt_r == 8'd0) begin
                        state_r <= ST_RESTORE;
                        cnt_r   <= RESTORE_LD;
                        out_r   <= state_outputs(ST_RESTORE);
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                ST_RESTORE: begin
                    if (cnt_r == 8'd0) begin
                        state_r <= ST_ON_ACK;
                        out_r   <= state_outputs(ST_ON_ACK);
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                ST_ON_ACK: begin
                    state_r <= ST_ON;
                    cnt_r   <= 8'd0;
                    out_r   <= state_outputs(ST_ON);
                end
                ST_ON: begin
                    if (power_off_req) begin
                        state_r <= ST_ISOLATE;
                        out_r   <= state_outputs(ST_ISOLATE);
                    end
                end
                ST_ISOLATE: begin
                    state_r <= ST_SAVE;
                    cnt_r   <= SAVE_LD;
                    out_r   <= state_outputs(ST_SAVE);
                end
                ST_SAVE: begin
`ifdef SAVE_TIMEOUT_EN
                    // A missing block ack is treated exactly like an ack once the budget runs out
                    if (ack_from_block_tb || (cnt_r == 8'd0)) begin
                        state_r <= ST_PWR_DN;
                        cnt_r   <= 8'd0;
                        out_r   <= state_outputs(ST_PWR_DN);
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
`else
                    if (ack_from_block_tb) begin
                        state_r <= ST_PWR_DN;
                        cnt_r   <= 8'd0;
                        out_r   <= state_outputs(ST_PWR_DN);
                    end
`endif
                end
                ST_PWR_DN: begin
                    state_r <= ST_OFF;
                    out_r   <= state_outputs(ST_OFF);
                end
                default: begin
                    state_r <= ST_OFF;
                    cnt_r   <= 8'd0;
                    out_r   <= state_outputs(ST_OFF);
                end
            endcase
        end
    end

    assign isolate_en      = out_r[5];
    assign power_switch_en = out_r[4];
    assign save_state      = out_r[3];
    assign restore_state   = out_r[2];
    assign power_on_ack    = out_r[1];
    assign power_off_ack   = out_r[0];

endmodule

// File: tb/tb_power_gating_top.sv
// Scoreboard bench for power_gating_top: a sequence-plan model pushes the expected output
// vector per edge; a negedge monitor pops and compares.
module tb_power_gating_top;

    localparam int RAMP    = 4;
    localparam int RESTORE = 2;
    localparam int TIMEOUT = 8;
`ifdef SAVE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // {iso, sw, save, rest, on_ack, off_ack}
    localparam logic [5:0] V_OFF   = 6'b100000;
    localparam logic [5:0] V_UP    = 6'b110000;
    localparam logic [5:0] V_REST  = 6'b110100;
    localparam logic [5:0] V_ONACK = 6'b010010;
    localparam logic [5:0] V_ON    = 6'b010000;
    localparam logic [5:0] V_ISO   = 6'b110000;
    localparam logic [5:0] V_SAVE  = 6'b111000;
    localparam logic [5:0] V_DN    = 6'b100001;

    localparam int M_OFF = 0, M_ON = 1, M_SAVE = 2, M_PLAN = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic power_on_req = 1'b0;
    logic power_off_req = 1'b0;
    logic ack_from_block_tb = 1'b0;
    logic isolate_en, save_state, restore_state, power_switch_en, power_on_ack, power_off_ack;

    power_gating_top #(
        .RAMP_CYCLES(RAMP), .RESTORE_CYCLES(RESTORE), .SAVE_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .power_on_req(power_on_req), .power_off_req(power_off_req),
        .ack_from_block_tb(ack_from_block_tb),
        .isolate_en(isolate_en), .save_state(save_state), .restore_state(restore_state),
        .power_switch_en(power_switch_en), .power_on_ack(power_on_ack), .power_off_ack(power_off_ack)
    );

    always #5 clk = ~clk;

    logic [5:0] sb[$];
    logic [5:0] plan[$];
    int mode = M_OFF;
    int after_mode = M_OFF;
    int save_cycles = 0;
    int n_total = 0;
    int n_pass = 0;
    int cyc = 0;

    // Reference: each accepted request expands into the full output sequence it must produce
    task automatic model_edge(input logic on, input logic off, input logic ack);
        logic [5:0] exp;
        exp = V_OFF;
        if (!rst_n) begin
            mode = M_OFF;
            plan.delete();
        end else begin
            case (mode)
                M_OFF: if (on) begin
                    for (int i = 0; i < RAMP; i++) plan.push_back(V_UP);
                    for (int i = 0; i < RESTORE; i++) plan.push_back(V_REST);
                    plan.push_back(V_ONACK);
                    plan.push_back(V_ON);
                    after_mode = M_ON;
                    mode = M_PLAN;
                end else exp = V_OFF;
                M_ON: if (off) begin
                    plan.push_back(V_ISO);
                    plan.push_back(V_SAVE);
                    save_cycles = 1;
                    after_mode = M_SAVE;
                    mode = M_PLAN;
                end else exp = V_ON;
                M_SAVE: if (ack || (TO_EN && save_cycles == TIMEOUT)) begin
                    plan.push_back(V_DN);
                    plan.push_back(V_OFF);
                    after_mode = M_OFF;
                    mode = M_PLAN;
                end else begin
                    save_cycles++;
                    exp = V_SAVE;
                end
                default: ;
            endcase
            if (mode == M_PLAN) begin
                exp = plan.pop_front();
                if (plan.size() == 0) mode = after_mode;
            end
        end
        sb.push_back(exp);
    endtask

    // Direct check of the present output vector
    task automatic check_now(input logic [5:0] e, input string what);
        logic [5:0] got;
        got = {isolate_en, power_switch_en, save_state, restore_state, power_on_ack, power_off_ack};
        n_total++;
        if (got === e) n_pass++;
        else $display("FAIL %s iso/sw/save/rest/onack/offack got=%b exp=%b", what, got, e);
    endtask

    task automatic step(input logic on, input logic off, input logic ack);
        power_on_req = on;
        power_off_req = off;
        ack_from_block_tb = ack;
        @(posedge clk);
        model_edge(on, off, ack);
        #1;
    endtask

    task automatic repeat_step(input int n, input logic on, input logic off, input logic ack);
        for (int i = 0; i < n; i++) step(on, off, ack);
    endtask

    // Reset asserted mid-cycle: outputs must already be at reset values at the next negedge
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        sb.delete();
        sb.push_back(V_OFF);
        mode = M_OFF;
        plan.delete();
        #1;
        check_now(V_OFF, "async reset");
        repeat_step(n, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    // Monitor: one expected vector per cycle
    always @(negedge clk) begin
        logic [5:0] got;
        logic [5:0] e;
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            got = {isolate_en, power_switch_en, save_state, restore_state, power_on_ack, power_off_ack};
            n_total++;
            if (got === e) n_pass++;
            else $display("FAIL outputs cyc=%0d iso/sw/save/rest/onack/offack got=%b exp=%b", cyc, got, e);
        end
    end

    initial begin
        #1;
        repeat_step(3, 1'b0, 1'b0, 1'b0);
        check_now(V_OFF, "reset state");
        rst_n = 1'b1;
        repeat_step(10, 1'b0, 1'b0, 1'b0);
        // Both requests in OFF: power-up, then ON held after requests drop
        step(1'b1, 1'b1, 1'b0);
        repeat_step(12, 1'b0, 1'b0, 1'b0);
        repeat_step(3, 1'b1, 1'b0, 1'b0);
        // Both requests in ON: power-down, save waits (or times out), then ack
        step(1'b1, 1'b1, 1'b0);
        repeat_step(20, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat_step(3, 1'b0, 1'b1, 1'b0);
        repeat_step(3, 1'b0, 1'b0, 1'b0);
        // Reset mid-RESTORE, then a clean power-up
        step(1'b1, 1'b0, 1'b0);
        repeat_step(RAMP + 1, 1'b0, 1'b0, 1'b0);
        do_reset(2);
        step(1'b1, 1'b0, 1'b0);
        repeat_step(10, 1'b0, 1'b0, 1'b0);
        // Reset mid-SAVE, then a clean power-up
        step(1'b0, 1'b1, 1'b0);
        repeat_step(4, 1'b0, 1'b0, 1'b0);
        do_reset(1);
        step(1'b1, 1'b0, 1'b0);
        repeat_step(10, 1'b0, 1'b0, 1'b0);
        // Long SAVE without ack, with ack already high on SAVE entry afterwards
        step(1'b0, 1'b1, 1'b0);
        repeat_step(100, 1'b0, 1'b0, 1'b0);
        check_now(TO_EN ? V_OFF : V_SAVE, "expired save wait");
        step(1'b0, 1'b0, 1'b1);
        repeat_step(4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat_step(10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        repeat_step(3, 1'b0, 1'b0, 1'b1);
        repeat_step(3, 1'b0, 1'b0, 1'b0);
        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 2));
            else step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
